mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the core's single memory port between two requesters: instruction fetch (port I) and data load/store (port D).
- Arbitrates, holds one transaction on the memory bus until `mem_ready`, then returns read data and a one-cycle completion pulse to the winning requester.
- Enforces a bounded wait with an error response.
- Sits between the processor's fetch/load-store sequencing and the memory/bus interface.

## Interface
Parameters:
- `TIMEOUT`, default 255: BUSY cycles tolerated without `mem_ready` before error completion; 0 disables the timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `if_valid` in 1: fetch request; held with `if_addr` stable until `if_ready`.
- `if_addr` in 32: fetch address.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out 32: fetch data, valid while `if_ready`.
- `if_err` out 1: fetch timed out, valid while `if_ready`.
- `d_valid` in 1: data request; held with `d_addr`, `d_wdata`, `d_wstrb` stable until `d_ready`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: byte enables; 0 means load.
- `d_ready` out 1: one-cycle completion pulse for data.
- `d_rdata` out 32: load data, valid while `d_ready`.
- `d_err` out 1: data timed out, valid while `d_ready`.
- `mem_valid` out 1: memory request.
- `mem_instr` out 1: 1 when the current request is a fetch.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory byte enables.
- `mem_ready` in 1: memory completion.
- `mem_rdata` in 32: memory read data, sampled when `mem_ready`.
- `busy` out 1: high in any state other than IDLE.
- `last_grant` out 1: 0 means the last grant went to I; 1 means D.

## Operation
States: IDLE, BUSY, RESP.

- **IDLE**
  - If no request is valid, stay.
  - Otherwise select the winner and register `mem_addr`.
    - Fetch win: `mem_wdata`=0, `mem_wstrb`=0, `mem_instr`=1.
    - Data win: `mem_wdata`=`d_wdata`, `mem_wstrb`=`d_wstrb`, `mem_instr`=0.
  - Set `mem_valid`=1, update `last_grant`, clear the wait counter, go BUSY.
- **BUSY**
  - Memory outputs are held constant.
  - On `mem_ready`=1: capture `mem_rdata`, set err=0, drop `mem_valid`, go RESP.
  - Else if `TIMEOUT`≠0 and counter==`TIMEOUT`: capture rdata=0, set err=1, drop `mem_valid` and `mem_wstrb`, go RESP.
  - Else increment the counter, saturating.
  - `mem_ready` in the timeout cycle wins; the transaction completes normally.
- **RESP**
  - Pulse the winner's ready for one cycle, with rdata/err.
  - The non-winner's ready stays 0. Its rdata/err hold their last values.
  - Go IDLE.
- Arbitration (default, fixed priority): D beats I when both are valid.
- `mem_rdata` is only sampled in BUSY with `mem_ready`=1. `mem_ready` outside BUSY is ignored.
- A requester must drop valid, or present a new request, in the cycle after its ready pulse. IDLE re-samples valid one cycle after RESP.
- The counter is wide enough to hold `TIMEOUT`.

## Timing
- Request seen in IDLE at cycle t → `mem_valid` high from t+1.
- `mem_ready` at cycle k (k ≥ t+1) → ready pulse at k+1 → IDLE at k+2.
- Minimum period: 3 cycles per transaction. Back-to-back requests are granted every 3 cycles.
- Timeout: `mem_valid` high for exactly `TIMEOUT`+1 cycles, then the err pulse in the next cycle.
- Reset values: every output 0, including `last_grant`; state IDLE; counter 0.
- `resetn` low in any state: next edge goes to IDLE with all outputs 0. The in-flight transaction is abandoned with no ready pulse.
- A requester dropping valid mid-transaction has no effect. The transaction completes and the pulse is still issued.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention, grant the port opposite to `last_grant`; after reset the first contention goes to D. A lone requester is always granted.
- Undefined: fixed priority, D over I. `last_grant` is still maintained.

## Test plan
- Lone fetch, `if_addr`=0x100, `mem_ready` returns 0x00000013 one cycle after `mem_valid` → `mem_instr`=1, `mem_wstrb`=0, `if_ready` pulse with `if_rdata`=0x00000013, `d_ready`=0.
- Store, `d_addr`=0x2004, `d_wdata`=0xDEADBEEF, `d_wstrb`=0011, `mem_ready` delayed 3 cycles → bus fields held stable for 4 cycles, `d_ready` pulse, `d_err`=0.
- Both valid continuously for 4 transactions:
  - Fixed priority → grants D, D, D, D.
  - With `MEM_ARB_RR_EN` → grants D, I, D, I.
- `TIMEOUT`=4, `mem_ready` never asserted → `mem_valid` high for 5 cycles, then `d_ready`=1 with `d_err`=1 and `d_rdata`=0. A new request afterwards is served normally.
- `resetn` low in the second BUSY cycle of a fetch → next edge `mem_valid`=0 and `busy`=0, no `if_ready` pulse. After release, a fetch to 0x0 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and
// data load/store (D). One transaction at a time: IDLE -> BUSY -> RESP.
// BUSY waits for mem_ready, bounded by TIMEOUT (0 disables the bound).
// Optional macro MEM_ARB_RR_EN: round-robin arbitration on contention;
// when undefined, D has fixed priority over I.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        last_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned  CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic            req_any;
    logic            grant_d;
    logic            timed_out;

    assign busy = (state != IDLE);

    // Arbitration and timeout detection
    always_comb begin
        req_any   = if_valid | d_valid;
`ifdef MEM_ARB_RR_EN
        // On contention grant the side opposite to the previous winner;
        // last_grant resets to I, so the first contention goes to D.
        grant_d   = d_valid & (~if_valid | ~last_grant);
`else
        grant_d   = d_valid;
`endif
        timed_out = (TIMEOUT != 0) && (wait_cnt == TMO_VAL);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = BUSY;
            BUSY:    if (mem_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Bus request, wait counter and response datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid  <= 1'b0;
            mem_instr  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            last_grant <= 1'b0;
            wait_cnt   <= '0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        mem_valid  <= 1'b1;
                        mem_instr  <= ~grant_d;
                        mem_addr   <= grant_d ? d_addr  : if_addr;
                        mem_wdata  <= grant_d ? d_wdata : '0;
                        mem_wstrb  <= grant_d ? d_wstrb : '0;
                        last_grant <= grant_d;
                        wait_cnt   <= '0;
                    end
                end
                BUSY: begin
                    // The ready pulse is registered here so it is high
                    // exactly during RESP; last_grant identifies the winner.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (last_grant) begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_rdata;
                            d_err   <= 1'b0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                            if_err   <= 1'b0;
                        end
                    end else if (timed_out) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        if (last_grant) begin
                            d_ready <= 1'b1;
                            d_rdata <= '0;
                            d_err   <= 1'b1;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= '0;
                            if_err   <= 1'b1;
                        end
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): table of single transactions
// plus hand sequences for timeout, timeout/ready race, reset mid-transaction
// and continuous contention.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        last_grant;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .if_valid   (if_valid),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_valid    (d_valid),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .last_grant (last_grant)
    );

    typedef struct {
        logic        ifv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        int          lat;
        logic [31:0] rd;
        logic        e_instr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction: request, mem_ready after v.lat wait cycles, pulse, idle.
    task automatic run_vec(input vec_t v);
        logic [71:0] bus_exp;
        @(negedge clk);
        if_valid  = v.ifv;  if_addr = v.ia;
        d_valid   = v.dv;   d_addr  = v.da; d_wdata = v.dw; d_wstrb = v.ds;
        mem_ready = 1'b0;   mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_exp = {2'b00, 1'b1, v.e_instr, v.e_wstrb, v.e_addr, v.e_wdata};
        chk("bus_grant", {2'b00, mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata}, bus_exp);
        for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            chk("bus_hold", {2'b00, mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata}, bus_exp);
        end
        mem_ready = 1'b1; mem_rdata = v.rd;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        chk("mem_valid_drop", 72'(mem_valid), 72'(0));
        if (v.e_instr) begin
            chk("if_pulse", 72'({if_ready, d_ready, if_err}), 72'(3'b100));
            chk("if_rdata", 72'(if_rdata), 72'(v.rd));
        end else begin
            chk("d_pulse", 72'({d_ready, if_ready, d_err}), 72'(3'b100));
            chk("d_rdata", 72'(d_rdata), 72'(v.rd));
        end
        if_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        chk("back_idle", 72'({busy, if_ready, d_ready}), 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_d;
        //         ifv  ia            dv    da            dw             ds      lat rd             instr e_addr        e_wdata        e_wstrb
        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0,         4'h0,   0, 32'h0000_0013, 1'b1, 32'h0000_0100, 32'h0,         4'h0};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0000_0000, 1'b0, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 32'h0000_3000, 32'h1111_2222, 4'h0,   1, 32'hCAFE_F00D, 1'b0, 32'h0000_3000, 32'h1111_2222, 4'h0};
        vecs[3] = '{1'b1, 32'h0000_0104, 1'b0, 32'h0000_9999, 32'hFFFF_FFFF, 4'hF,   0, 32'h0000_0093, 1'b1, 32'h0000_0104, 32'h0,         4'h0};
        vecs[4] = '{1'b1, 32'h0000_0108, 1'b0, 32'h0,        32'h0,         4'h0,   2, 32'h1234_5678, 1'b1, 32'h0000_0108, 32'h0,         4'h0};
        vecs[5] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,         4'h0,   1, 32'h0BAD_F00D, 1'b1, 32'h0000_0000, 32'h0,         4'h0};

        resetn = 1'b0; if_valid = 1'b0; if_addr = '0; d_valid = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp", 72'({if_ready, if_rdata, if_err, d_ready, d_err}), 72'(0));
        chk("reset_bus", 72'({d_rdata, mem_valid, mem_instr, mem_wstrb, busy, last_grant}), 72'(0));
        chk("reset_addr", {mem_addr, mem_wdata, 8'h00}, 72'(0));
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Timeout: mem_valid high for 5 cycles, then error pulse with rdata 0
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h6000; d_wdata = 32'h55; d_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tmo_valid_high", 72'({mem_valid, mem_wstrb}), 72'(5'b11111));
        end
        @(negedge clk);
        chk("tmo_pulse", 72'({d_ready, d_err, if_ready}), 72'(3'b110));
        chk("tmo_rdata", 72'(d_rdata), 72'(0));
        chk("tmo_bus_drop", 72'({mem_valid, mem_wstrb}), 72'(0));
        chk("tmo_if_hold", 72'(if_rdata), 72'(32'h1234_5678));
        d_valid = 1'b0;
        @(negedge clk);
        chk("tmo_idle", 72'({busy, d_ready}), 72'(0));
        run_vec(vecs[2]);

        // mem_ready in the timeout cycle wins: normal completion
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h7000; d_wstrb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("race_valid_high", 72'(mem_valid), 72'(1));
            if (i == 4) begin mem_ready = 1'b1; mem_rdata = 32'h0000_0777; end
        end
        @(negedge clk);
        mem_ready = 1'b0; d_valid = 1'b0;
        chk("race_pulse", 72'({d_ready, d_err}), 72'(2'b10));
        chk("race_rdata", 72'(d_rdata), 72'(32'h777));
        @(negedge clk);

        // Reset in the second BUSY cycle of a fetch abandons it
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h200;
        @(negedge clk);
        chk("rst_busy1", 72'({mem_valid, mem_instr, busy}), 72'(3'b111));
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_drop", 72'({mem_valid, busy, if_ready, last_grant}), 72'(0));
        chk("rst_addr", 72'(mem_addr), 72'(0));
        if_valid = 1'b0; resetn = 1'b1;
        @(negedge clk);
        chk("rst_no_pulse", 72'({if_ready, busy}), 72'(0));
        run_vec(vecs[5]);

        // Continuous contention for 4 transactions (last_grant is I here)
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h700; d_valid = 1'b1; d_addr = 32'h800; d_wstrb = 4'h0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_d = (n % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            chk("cont_grant", 72'({mem_valid, mem_instr, last_grant}), 72'({1'b1, ~exp_d, exp_d}));
            mem_ready = 1'b1; mem_rdata = 32'(n);
            @(negedge clk);
            mem_ready = 1'b0;
            chk("cont_pulse", 72'({if_ready, d_ready}), 72'({~exp_d, exp_d}));
            @(negedge clk);
            chk("cont_idle", 72'(busy), 72'(0));
        end
        if_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        chk("final_idle", 72'({busy, mem_valid}), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
